// File: rtl/game_input_pkg.sv
// Shared types and default timing for the player-control input conditioner.
package game_input_pkg;

    // Auto-repeat sequencer states
    typedef enum logic [1:0] {
        REP_IDLE   = 2'd0,
        REP_DELAY  = 2'd1,
        REP_REPEAT = 2'd2
    } rep_state_t;

    localparam int unsigned CLK_HZ = 50_000_000;

    // 10 ms debounce, 500 ms to first repeat, 100 ms between repeats
    localparam int unsigned DEFAULT_DEBOUNCE      = CLK_HZ / 100;
    localparam int unsigned DEFAULT_REPEAT_DELAY  = CLK_HZ / 2;
    localparam int unsigned DEFAULT_REPEAT_PERIOD = CLK_HZ / 10;

endpackage

// File: rtl/input_channel.sv
// One control channel: synchroniser, debounce, edge strobes, optional auto-repeat.
//
// state      | meaning
// -----------+------------------------------------------------------------
// REP_IDLE   | button released (or just released); no repeat activity
// REP_DELAY  | button held, waiting for the first repeat after the press
// REP_REPEAT | button held, issuing a repeat every REPEAT_PERIOD cycles
module input_channel
    import game_input_pkg::*;
#(
    parameter bit          INVERT          = 1'b1,
    parameter bit          REPEAT_EN       = 1'b0,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
    parameter int unsigned REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic fire_pulse
);

    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          s;
    logic [DW-1:0] dcnt;
    logic          deb_hit;
    logic          rise;
    logic          fall;
    logic          rep_hit;

    // Two-flop synchroniser; reset to the idle pin level so s starts at 0
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= INVERT;
            sync2 <= INVERT;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    assign s       = sync2 ^ INVERT;
    assign deb_hit = (s != level) && (dcnt == DCNT_LAST);
    assign rise    = deb_hit & s;
    assign fall    = deb_hit & ~s;

    // Debounce counter, stable level and edge strobes
    always_ff @(posedge clk) begin
        if (reset) begin
            level         <= 1'b0;
            dcnt          <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= rise;
            release_pulse <= fall;
            if (s == level) begin
                dcnt <= '0;
            end else if (deb_hit) begin
                level <= s;
                dcnt  <= '0;
            end else begin
                dcnt <= dcnt + DW'(1);
            end
        end
    end

    generate
        if (REPEAT_EN) begin : g_repeat
            localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
            localparam int unsigned RW   = $clog2(RMAX + 1);
            localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
            localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

            rep_state_t    state;
            rep_state_t    state_nxt;
            logic [RW-1:0] rcnt;
            logic [RW-1:0] rcnt_nxt;

            // Repeat FSM state register
            always_ff @(posedge clk) begin
                if (reset) begin
                    state <= REP_IDLE;
                    rcnt  <= '0;
                end else begin
                    state <= state_nxt;
                    rcnt  <= rcnt_nxt;
                end
            end

            // Next state and repeat strobe; a release overrides any due repeat
            always_comb begin
                state_nxt = state;
                rcnt_nxt  = rcnt;
                rep_hit   = 1'b0;
                case (state)
                    REP_IDLE: begin
                        if (rise) begin
                            state_nxt = REP_DELAY;
                            rcnt_nxt  = '0;
                        end
                    end
                    REP_DELAY: begin
                        if (rcnt == DELAY_LAST) begin
                            rep_hit   = 1'b1;
                            rcnt_nxt  = '0;
                            state_nxt = REP_REPEAT;
                        end else begin
                            rcnt_nxt = rcnt + RW'(1);
                        end
                    end
                    REP_REPEAT: begin
                        if (rcnt == PERIOD_LAST) begin
                            rep_hit  = 1'b1;
                            rcnt_nxt = '0;
                        end else begin
                            rcnt_nxt = rcnt + RW'(1);
                        end
                    end
                    default: begin
                        state_nxt = REP_IDLE;
                        rcnt_nxt  = '0;
                    end
                endcase
                if (fall) begin
                    state_nxt = REP_IDLE;
                    rcnt_nxt  = '0;
                    rep_hit   = 1'b0;
                end
            end
        end else begin : g_no_repeat
            assign rep_hit = 1'b0;
        end
    endgenerate

    // Fire strobe: press edge plus any auto-repeat
    always_ff @(posedge clk) begin
        if (reset) begin
            fire_pulse <= 1'b0;
        end else begin
            fire_pulse <= rise | rep_hit;
        end
    end

endmodule

// File: rtl/game_input_conditioner.sv
// N-channel player-control front end: one input_channel per pin.
module game_input_conditioner
    import game_input_pkg::*;
#(
    parameter int unsigned          N_CH            = 4,
    parameter logic [N_CH-1:0]      INVERT_MASK     = {N_CH{1'b1}},
    parameter logic [N_CH-1:0]      REPEAT_MASK     = {N_CH{1'b0}},
    parameter int unsigned          DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
    parameter int unsigned          REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int unsigned          REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
    input  logic            CLOCK_50,
    input  logic            reset,
    input  logic [N_CH-1:0] raw_in,
    output logic [N_CH-1:0] level_out,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] fire_pulse
);

    generate
        for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
            input_channel #(
                .INVERT          (INVERT_MASK[i]),
                .REPEAT_EN       (REPEAT_MASK[i]),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .REPEAT_DELAY    (REPEAT_DELAY),
                .REPEAT_PERIOD   (REPEAT_PERIOD)
            ) u_ch (
                .clk           (CLOCK_50),
                .reset         (reset),
                .raw           (raw_in[i]),
                .level         (level_out[i]),
                .press_pulse   (press_pulse[i]),
                .release_pulse (release_pulse[i]),
                .fire_pulse    (fire_pulse[i])
            );
        end
    endgenerate

endmodule
